// File: rtl/rc_pwm_decoder_pkg.sv
// Shared definitions for the RC PWM receive path.
// Holds the command codes shared with the pulse generator, the per-channel
// measurement FSM state encoding, and the default width tick unit.
package rc_pwm_decoder_pkg;

  // Width tick unit in clk cycles; the pulse generator uses the same unit.
  localparam int unsigned CLK_DIV_DEFAULT = 1953;

  // Steering command codes
  localparam logic [1:0] CMD_LEFT    = 2'd1;
  localparam logic [1:0] CMD_RIGHT   = 2'd2;
  localparam logic [1:0] CMD_NEUTRAL = 2'd3;

  // Throttle command codes
  localparam logic [1:0] CMD_REV     = 2'd1;
  localparam logic [1:0] CMD_FWD     = 2'd2;
  localparam logic [1:0] CMD_STOP    = 2'd3;

  // Per-channel width meter states
  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_ARMED    = 2'd1,
    ST_MEASURE  = 2'd2
  } meter_state_t;

endpackage

// File: rtl/rc_pwm_decoder_meter.sv
// pwm_width_meter: measures the high time of one raw PWM input in width ticks.
// Ports:
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_pwm          - raw asynchronous pulse input
//   i_tick         - one-cycle strobe every CLK_DIV cycles (shared prescaler)
//   o_width        - width of the most recently accepted pulse, in ticks
//   o_accept       - one-cycle strobe when a pulse within [MIN_W, MAX_W] ends
//   o_timed_out    - one-cycle strobe when TIMEOUT_TICKS ticks pass with no accept
module pwm_width_meter
  import rc_pwm_decoder_pkg::*;
#(
  parameter int unsigned CLK_DIV       = CLK_DIV_DEFAULT,
  parameter int unsigned MIN_W         = 20,
  parameter int unsigned MAX_W         = 200,
  parameter int unsigned TIMEOUT_TICKS = 1536
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pwm,
  input  logic       i_tick,
  output logic [7:0] o_width,
  output logic       o_accept,
  output logic       o_timed_out
);

  localparam int unsigned   PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    MIN_W8     = 8'(MIN_W);
  localparam logic [7:0]    MAX_W8     = 8'(MAX_W);
  localparam logic [10:0]   TO_LAST    = 11'(TIMEOUT_TICKS - 1);
  localparam logic [10:0]   TO_MAX     = '1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  meter_state_t  r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_width;
  logic          r_sat;
  logic [7:0]    r_width_out;
  logic          r_accept;
  logic [10:0]   r_to_cnt;

  logic          w_rise;
  logic          w_fall;
  logic          w_wrap;
  logic [7:0]    w_width_cnt;
  logic          w_sat_cnt;
  logic          w_accept_now;

  // Synchronizer stage; the third flop only serves edge detection.
  // These flops are left unreset so they keep tracking the pin during reset,
  // which lets WAIT_LOW see a pulse that is already high at reset release.
  always_ff @(posedge i_clk) begin
    r_sync1 <= i_pwm;
    r_sync2 <= r_sync1;
    r_sync3 <= r_sync2;
  end

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;
  assign w_wrap = (r_presc == PRESC_LAST);

  // Width after this cycle's prescaler step. The measure state counts on the
  // falling-edge cycle too, so a wrap coinciding with the fall is included.
  always_comb begin
    w_width_cnt = r_width;
    w_sat_cnt   = r_sat;
    if (w_wrap) begin
      if (r_width == 8'hFF) begin
        w_sat_cnt = 1'b1;
      end else begin
        w_width_cnt = r_width + 8'd1;
      end
    end
  end

  assign w_accept_now = (r_state == ST_MEASURE) && w_fall && !w_sat_cnt &&
                        (w_width_cnt >= MIN_W8) && (w_width_cnt <= MAX_W8);

  // Measurement FSM stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_WAIT_LOW;
      r_presc     <= '0;
      r_width     <= '0;
      r_sat       <= 1'b0;
      r_accept    <= 1'b0;
      r_width_out <= '0;
    end else begin
      r_accept <= 1'b0;
      case (r_state)
        ST_WAIT_LOW: begin
          if (!r_sync2) begin
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_rise) begin
            // Starting at half a tick makes the final count round to nearest.
            r_state <= ST_MEASURE;
            r_presc <= PRESC_HALF;
            r_width <= '0;
            r_sat   <= 1'b0;
          end
        end
        ST_MEASURE: begin
          r_presc <= w_wrap ? '0 : r_presc + 1'b1;
          r_width <= w_width_cnt;
          r_sat   <= w_sat_cnt;
          if (w_fall) begin
            r_state <= ST_ARMED;
            if (w_accept_now) begin
              r_accept    <= 1'b1;
              r_width_out <= w_width_cnt;
            end
          end
        end
        default: r_state <= ST_WAIT_LOW;
      endcase
    end
  end

  // Timeout stage: counts shared ticks since the last accepted pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (w_accept_now) begin
      r_to_cnt <= '0;
    end else if (i_tick && (r_to_cnt != TO_MAX)) begin
      r_to_cnt <= r_to_cnt + 11'd1;
    end
  end

  // Fires on the tick that brings the count to TIMEOUT_TICKS; a pulse being
  // accepted on the same cycle clears the counter and suppresses it.
  assign o_timed_out = i_tick && (r_to_cnt == TO_LAST) && !w_accept_now;
  assign o_accept    = r_accept;
  assign o_width     = r_width_out;

endmodule

// File: rtl/rc_pwm_decoder.sv
// rc_pwm_decoder: receive side of the RC servo/ESC PWM interface.
// Measures steering and throttle pulse high times and turns them into the
// 2-bit command codes consumed by the control mux, with failsafe on timeout.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   steer_pwm_in, throttle_pwm_in    - raw asynchronous pulse inputs
//   direction                        - 1=left, 2=right, 3=neutral
//   throttle                         - 1=reverse, 2=forward, 3=stop
//   steer_width, throttle_width      - last accepted width, in ticks
//   steer_valid, throttle_valid      - high while pulses are current
//   steer_sample, throttle_sample    - one-cycle strobe per accepted pulse
module rc_pwm_decoder
  import rc_pwm_decoder_pkg::*;
#(
  parameter int unsigned CLK_DIV        = CLK_DIV_DEFAULT,
  parameter int unsigned MIN_W          = 20,
  parameter int unsigned MAX_W          = 200,
  parameter int unsigned STEER_LEFT_TH  = 88,
  parameter int unsigned STEER_RIGHT_TH = 62,
  parameter int unsigned THR_FWD_TH     = 83,
  parameter int unsigned THR_REV_TH     = 62,
  parameter int unsigned TIMEOUT_TICKS  = 1536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       steer_pwm_in,
  input  logic       throttle_pwm_in,
  output logic [1:0] direction,
  output logic [1:0] throttle,
  output logic [7:0] steer_width,
  output logic [7:0] throttle_width,
  output logic       steer_valid,
  output logic       throttle_valid,
  output logic       steer_sample,
  output logic       throttle_sample
);

  localparam int unsigned   PW            = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST     = PW'(CLK_DIV - 1);
  localparam logic [7:0]    STEER_LEFT_W  = 8'(STEER_LEFT_TH);
  localparam logic [7:0]    STEER_RIGHT_W = 8'(STEER_RIGHT_TH);
  localparam logic [7:0]    THR_FWD_W     = 8'(THR_FWD_TH);
  localparam logic [7:0]    THR_REV_W     = 8'(THR_REV_TH);

  logic [PW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [7:0]    w_steer_width;
  logic [7:0]    w_thr_width;
  logic          w_steer_accept;
  logic          w_thr_accept;
  logic          w_steer_to;
  logic          w_thr_to;

  function automatic logic [1:0] decode_steer(input logic [7:0] w);
    logic [1:0] code;
    code = CMD_NEUTRAL;
    if (w >= STEER_LEFT_W) begin
      code = CMD_LEFT;
    end else if (w <= STEER_RIGHT_W) begin
      code = CMD_RIGHT;
    end
    return code;
  endfunction

  function automatic logic [1:0] decode_throttle(input logic [7:0] w);
    logic [1:0] code;
    code = CMD_STOP;
    if (w >= THR_FWD_W) begin
      code = CMD_FWD;
    end else if (w <= THR_REV_W) begin
      code = CMD_REV;
    end
    return code;
  endfunction

  // Shared free-running tick prescaler used by both timeout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  pwm_width_meter #(
    .CLK_DIV       (CLK_DIV),
    .MIN_W         (MIN_W),
    .MAX_W         (MAX_W),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_steer_meter (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pwm       (steer_pwm_in),
    .i_tick      (w_tick),
    .o_width     (w_steer_width),
    .o_accept    (w_steer_accept),
    .o_timed_out (w_steer_to)
  );

  pwm_width_meter #(
    .CLK_DIV       (CLK_DIV),
    .MIN_W         (MIN_W),
    .MAX_W         (MAX_W),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_thr_meter (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pwm       (throttle_pwm_in),
    .i_tick      (w_tick),
    .o_width     (w_thr_width),
    .o_accept    (w_thr_accept),
    .o_timed_out (w_thr_to)
  );

  // Output decode stage: an accept always takes priority over a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      direction       <= CMD_NEUTRAL;
      throttle        <= CMD_STOP;
      steer_width     <= '0;
      throttle_width  <= '0;
      steer_valid     <= 1'b0;
      throttle_valid  <= 1'b0;
      steer_sample    <= 1'b0;
      throttle_sample <= 1'b0;
    end else begin
      steer_sample    <= w_steer_accept;
      throttle_sample <= w_thr_accept;

      if (w_steer_accept) begin
        steer_width <= w_steer_width;
        direction   <= decode_steer(w_steer_width);
        steer_valid <= 1'b1;
      end else if (w_steer_to) begin
        steer_valid <= 1'b0;
        direction   <= CMD_NEUTRAL;
      end

      if (w_thr_accept) begin
        throttle_width <= w_thr_width;
        throttle       <= decode_throttle(w_thr_width);
        throttle_valid <= 1'b1;
      end else if (w_thr_to) begin
        throttle_valid <= 1'b0;
        throttle       <= CMD_STOP;
      end
    end
  end

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Self-checking bench for rc_pwm_decoder with CLK_DIV=8.
// A behavioural model derives every expected output from the raw input
// waveform (high-time in cycles, rounding, thresholds, tick-based timeout);
// directed pulses carry hand-computed literal expectations as well.
module tb_rc_pwm_decoder;

  localparam int D     = 8;
  localparam int TO    = 1536;
  localparam int MIN_W = 20;
  localparam int MAX_W = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       steer_in = 1'b0;
  logic       thr_in = 1'b0;
  logic [1:0] direction;
  logic [1:0] throttle;
  logic [7:0] steer_width;
  logic [7:0] throttle_width;
  logic       steer_valid;
  logic       throttle_valid;
  logic       steer_sample;
  logic       throttle_sample;

  int total = 0;
  int bad   = 0;

  rc_pwm_decoder #(.CLK_DIV(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .steer_pwm_in    (steer_in),
    .throttle_pwm_in (thr_in),
    .direction       (direction),
    .throttle        (throttle),
    .steer_width     (steer_width),
    .throttle_width  (throttle_width),
    .steer_valid     (steer_valid),
    .throttle_valid  (throttle_valid),
    .steer_sample    (steer_sample),
    .throttle_sample (throttle_sample)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int ecnt = 0;
  int m_run[2];
  int m_due[2];
  int m_clr[2];
  int m_clr_due[2];
  int m_pw[2];
  bit m_ok[2];
  bit m_seen[2];
  int m_valid[2];
  int m_sample[2];
  int m_code[2];
  int m_width[2];

  function automatic int decode(input int ch, input int w);
    if (ch == 0) return (w >= 88) ? 1 : ((w <= 62) ? 2 : 3);
    return (w >= 83) ? 2 : ((w <= 62) ? 1 : 3);
  endfunction

  // Edge at which the TO-th tick strictly after clear edge c occurs;
  // ticks land on edges that are multiples of D after reset release.
  function automatic int expiry(input int c);
    return (c / D + TO) * D;
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit raw;
    if (rst) begin
      ecnt = 0;
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0; m_due[c] = -1; m_clr[c] = 0; m_clr_due[c] = -1; m_pw[c] = 0;
        m_ok[c] = 0; m_seen[c] = 0; m_valid[c] = 0; m_sample[c] = 0;
        m_code[c] = 3; m_width[c] = 0;
      end
    end else begin
      ecnt++;
      for (int c = 0; c < 2; c++) begin
        raw = (c == 0) ? steer_in : thr_in;
        m_sample[c] = 0;
        if (ecnt == expiry(m_clr[c]) && m_clr_due[c] != ecnt) begin
          m_valid[c] = 0;
          m_code[c]  = 3;
        end
        if (m_clr_due[c] == ecnt) begin
          m_clr[c] = ecnt;
          m_clr_due[c] = -1;
        end
        if (m_due[c] == ecnt) begin
          m_width[c]  = m_pw[c];
          m_code[c]   = decode(c, m_pw[c]);
          m_valid[c]  = 1;
          m_sample[c] = 1;
          m_due[c]    = -1;
        end
        if (raw) begin
          if (m_run[c] == 0) m_ok[c] = m_seen[c];
          m_run[c]++;
        end else begin
          m_seen[c] = 1;
          if (m_run[c] > 0 && m_ok[c]) begin
            w = (m_run[c] + D / 2) / D;
            if (w >= MIN_W && w <= MAX_W) begin
              m_pw[c] = w;
              m_due[c] = ecnt + 3;
              m_clr_due[c] = ecnt + 2;
            end
          end
          m_run[c] = 0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_cycle();
    check("cmp_direction",  int'(direction),       m_code[0]);
    check("cmp_throttle",   int'(throttle),        m_code[1]);
    check("cmp_steer_w",    int'(steer_width),     m_width[0]);
    check("cmp_thr_w",      int'(throttle_width),  m_width[1]);
    check("cmp_steer_vld",  int'(steer_valid),     m_valid[0]);
    check("cmp_thr_vld",    int'(throttle_valid),  m_valid[1]);
    check("cmp_steer_smp",  int'(steer_sample),    m_sample[0]);
    check("cmp_thr_smp",    int'(throttle_sample), m_sample[1]);
  endtask

  function automatic int o_sample(input int ch);
    return (ch == 0) ? int'(steer_sample) : int'(throttle_sample);
  endfunction
  function automatic int o_width(input int ch);
    return (ch == 0) ? int'(steer_width) : int'(throttle_width);
  endfunction
  function automatic int o_code(input int ch);
    return (ch == 0) ? int'(direction) : int'(throttle);
  endfunction
  function automatic int o_valid(input int ch);
    return (ch == 0) ? int'(steer_valid) : int'(throttle_valid);
  endfunction

  task automatic drive(input int ch, input bit v);
    if (ch == 0) steer_in = v;
    else         thr_in   = v;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    @(negedge clk) drive(ch, 1'b1);
    repeat (hi) @(negedge clk);
    drive(ch, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  // Pulse of hi cycles; results must appear on the 4th edge after the fall.
  task automatic pulse_chk(input string nm, input int ch, input int hi, input int lo,
                           input bit acc, input int w, input int code);
    @(negedge clk) drive(ch, 1'b1);
    repeat (hi) @(negedge clk);
    drive(ch, 1'b0);
    repeat (3) @(negedge clk);
    check({nm, "_early_smp"}, o_sample(ch), 0);
    @(negedge clk);
    check({nm, "_smp"},   o_sample(ch), acc ? 1 : 0);
    check({nm, "_width"}, o_width(ch),  w);
    check({nm, "_code"},  o_code(ch),   code);
    check({nm, "_valid"}, o_valid(ch),  1);
    @(negedge clk);
    check({nm, "_smp_end"}, o_sample(ch), 0);
    repeat (lo - 5) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int strobes;

    repeat (5) @(negedge clk);
    check("rst_direction", int'(direction), 3);
    check("rst_throttle",  int'(throttle), 3);
    check("rst_steer_w",   int'(steer_width), 0);
    check("rst_thr_w",     int'(throttle_width), 0);
    check("rst_steer_vld", int'(steer_valid), 0);
    check("rst_thr_vld",   int'(throttle_valid), 0);
    check("rst_steer_smp", int'(steer_sample), 0);
    check("rst_thr_smp",   int'(throttle_sample), 0);
    rst = 1'b0;

    fork
      forever @(negedge clk) compare_cycle();
    join_none

    repeat (4) @(negedge clk);

    // 100-tick steering pulse
    pulse_chk("steer100", 0, 800, 3296, 1'b1, 100, 1);

    // Throttle reverse / forward / stop, then a rounded width
    pulse_chk("thr50", 1, 400, 3296, 1'b1, 50, 1);
    pulse_chk("thr90", 1, 720, 3296, 1'b1, 90, 2);
    pulse_chk("thr75", 1, 600, 3296, 1'b1, 75, 3);
    pulse_chk("thr82", 1, 659, 3296, 1'b1, 82, 3);

    // Glitch below MIN_W and a saturating pulse: both rejected
    pulse_chk("glitch", 1, 80,   3296, 1'b0, 82, 3);
    pulse_chk("satur",  1, 2100, 3296, 1'b0, 82, 3);
    pulse_chk("thr75b", 1, 600,  3296, 1'b1, 75, 3);

    // Pulse in progress across reset release is discarded
    @(negedge clk) steer_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    steer_in = 1'b0;
    strobes = 0;
    repeat (8) begin
      @(negedge clk);
      strobes += int'(steer_sample);
    end
    check("rstmid_strobes", strobes, 0);
    check("rstmid_direction", int'(direction), 3);
    check("rstmid_valid", int'(steer_valid), 0);
    repeat (3000) @(negedge clk);
    pulse_chk("steer_after_rst", 0, 800, 3296, 1'b1, 100, 1);

    // Steering timeout while throttle keeps pulsing
    fork
      begin
        @(negedge clk) steer_in = 1'b1;
        repeat (800) @(negedge clk);
        steer_in = 1'b0;
        repeat (4) @(negedge clk);
        check("to_accept_smp", int'(steer_sample), 1);
        check("to_accept_dir", int'(direction), 1);
        n = 0;
        while (steer_valid && n < 13000) begin
          @(negedge clk);
          n++;
        end
        check("to_delay_in_range", int'(n >= TO * D - D && n <= TO * D - 1), 1);
        check("to_direction", int'(direction), 3);
        check("to_width_kept", int'(steer_width), 100);
        check("to_thr_valid", int'(throttle_valid), 1);
      end
      begin
        repeat (4) pulse(1, 720, 3376);
      end
    join

    // Coincident falling edges on both channels
    @(negedge clk) thr_in = 1'b1;
    repeat (320) @(negedge clk);
    steer_in = 1'b1;
    repeat (400) @(negedge clk);
    steer_in = 1'b0;
    thr_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("coinc_early_smp", int'(steer_sample | throttle_sample), 0);
    @(negedge clk);
    check("coinc_steer_smp", int'(steer_sample), 1);
    check("coinc_thr_smp",   int'(throttle_sample), 1);
    check("coinc_direction", int'(direction), 2);
    check("coinc_throttle",  int'(throttle), 2);
    check("coinc_steer_w",   int'(steer_width), 50);
    check("coinc_thr_w",     int'(throttle_width), 90);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
